saw_gen: RTL and testbench
==========================

# saw_gen

Phase-accumulator sawtooth oscillator for the synth voice path, directly upstream of the rectangle/PWM comparator stage. It produces the 11-bit unsigned sawtooth that the comparator thresholds against its PWM level. It also provides a wrap strobe for oscillator hard-sync chaining. Frequency words arrive over a valid/ready handshake, and portamento (glide) between frequencies can optionally be compiled in.

## Interface
- ACC_W, 24: phase accumulator width (bits); must be ≥ OUT_W + 1
- OUT_W, 11: sawtooth output width (matches downstream comparator)
- GLIDE_SHIFT, 8: glide step divisor exponent (step = diff >>> GLIDE_SHIFT)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- tick_en  in  1  sample-rate strobe; accumulator advances only when high
- freq_in  in  ACC_W  phase increment (unsigned) per tick
- freq_valid  in  1  freq_in valid
- freq_ready  out  1  block can accept freq_in
- sync_in  in  1  hard-sync request; rising edge clears phase
- saw_out  out  OUT_W  sawtooth = phase[ACC_W-1 -: OUT_W], unsigned
- wrap_pulse  out  1  one-cycle strobe on natural accumulator overflow

## Operation
- Registers:
  - phase [ACC_W]
  - inc_cur [ACC_W], the increment in use
  - inc_tgt [ACC_W]
  - sync_q, the registered sync_in
  - state ∈ {IDLE, GLIDE}
- Reset (rst=0): phase=0, inc_cur=0, inc_tgt=0, sync_q=0, state=IDLE, saw_out=0, wrap_pulse=0, freq_ready=1.
- Handshake:
  - A transfer occurs at a rising edge with freq_valid=1 and freq_ready=1; freq_in is captured into inc_tgt.
  - A sender holding valid while ready=0 is not accepted; data must be held.
- Phase update, in priority order each edge:
  1. Sync: sync_in=1 and sync_q=0 → phase=0. tick_en is ignored that cycle and wrap_pulse=0.
  2. Tick: tick_en=1 → phase = (phase + inc_cur) mod 2^ACC_W. wrap_pulse=1 iff the addition carries out of bit ACC_W-1.
  3. Otherwise phase holds and wrap_pulse=0.
- sync_q <= sync_in every cycle. A level held high clears the phase only once.
- Without glide, the accept edge sets inc_cur=freq_in directly. state stays IDLE and freq_ready stays 1.
- Glide FSM:
  - IDLE: on accept with freq_in ≠ inc_cur → GLIDE and freq_ready=0. Accept with freq_in == inc_cur stays in IDLE.
  - GLIDE: on each tick_en, d = inc_tgt − inc_cur (signed, ACC_W+1 bits) and s = d >>> GLIDE_SHIFT. If s=0, use s = sign(d) (±1). Then inc_cur += s.
  - When inc_cur == inc_tgt after an update → IDLE, and freq_ready=1 from the next cycle.
  - The glide never overshoots.
- No arithmetic saturates except the glide step. Phase wraps modulo 2^ACC_W.

## Timing
- saw_out and wrap_pulse are combinational views of registered state, so each reflects the edge at which phase updated.
- An increment accepted at edge E is first used by a tick at edge E+1 or later. A tick at edge E uses the old inc_cur.
- In GLIDE, the phase update and the inc_cur step on the same tick are simultaneous: the phase adds the pre-step inc_cur.
- A sync rising edge sampled at edge E gives phase=0 visible after E.
- Reset may assert mid-glide or mid-handshake: all state clears immediately and any in-flight freq word is dropped.

## Configuration
- GLIDE_EN defined: the glide FSM and GLIDE_SHIFT stepping are compiled in.
- GLIDE_EN undefined: there is no FSM. freq_ready is tied to 1, inc_tgt is unused, and an accepted word loads inc_cur directly. GLIDE_SHIFT is ignored.

## Test plan
- Steady ramp: default params, no glide.
  - Stimulus: accept freq_in=0x010000, tick_en=1 continuously.
  - Response: saw_out steps 0,8,16,…,2040, then returns to 0, with wrap_pulse=1 on exactly that cycle, once per 256 ticks.
- Zero frequency: freq_in=0 with ticks running → saw_out constant and wrap_pulse never asserts.
- Hard sync:
  - Stimulus: mid-ramp (saw_out=800), drive sync_in 0→1 and hold it high 10 cycles.
  - Response: saw_out=0 on the next cycle, then ramps normally with no further clears.
- Sync and tick collide: sync rising edge and tick_en on the same edge, with phase near overflow → phase=0 and wrap_pulse=0.
- Glide (GLIDE_EN):
  - Stimulus: from inc_cur=0, accept 0x000400.
  - Response: inc_cur rises monotonically with steps ≥1 and never exceeds 0x000400. freq_ready=0 until inc_cur=0x000400, then 1. A freq_valid pulse during GLIDE is not accepted.
- Reset mid-glide: assert rst=0 during GLIDE → saw_out=0, wrap_pulse=0, freq_ready=1. After release, a new accept works normally.

Source files
------------

// File: rtl/saw_gen.sv
// Phase-accumulator sawtooth oscillator with hard-sync and a wrap strobe for sync chaining.
// Build with GLIDE_EN defined to compile in portamento between accepted frequency words.
module saw_gen #(
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 11,
  parameter int GLIDE_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic [ACC_W-1:0] freq_in,
  input  logic             freq_valid,
  output logic             freq_ready,
  input  logic             sync_in,
  output logic [OUT_W-1:0] saw_out,
  output logic             wrap_pulse
);

  logic [ACC_W-1:0] phase, inc_cur;
  logic             sync_q, wrap_q;
  logic [ACC_W:0]   sum;
  logic             accept;

  assign accept     = freq_valid && freq_ready;
  assign sum        = {1'b0, phase} + {1'b0, inc_cur};
  assign saw_out    = phase[ACC_W-1 -: OUT_W];
  assign wrap_pulse = wrap_q;

  // Sync edge beats tick; a held sync level clears only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      sync_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      sync_q <= sync_in;
      if (sync_in && !sync_q) begin
        phase  <= '0;
        wrap_q <= 1'b0;
      end else if (tick_en) begin
        phase  <= sum[ACC_W-1:0];
        wrap_q <= sum[ACC_W];
      end else begin
        wrap_q <= 1'b0;
      end
    end
  end

`ifdef GLIDE_EN
  typedef enum logic {IDLE, GLIDE} state_t;

  state_t                state, state_nxt;
  logic [ACC_W-1:0]      inc_tgt, tgt_nxt, inc_nxt;
  logic signed [ACC_W:0] diff, step;

  assign diff = $signed({1'b0, inc_tgt}) - $signed({1'b0, inc_cur});

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = inc_tgt;
    inc_nxt    = inc_cur;
    freq_ready = (state == IDLE);
    step       = diff >>> GLIDE_SHIFT;
    // Small differences would shift to zero; crawl the last bit(s) one LSB at a time.
    if (step == '0 && diff != '0)
      step = diff[ACC_W] ? '1 : {{ACC_W{1'b0}}, 1'b1};
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_nxt = freq_in;
          if (freq_in != inc_cur) state_nxt = GLIDE;
        end
      end
      GLIDE: begin
        if (tick_en) begin
          inc_nxt = ACC_W'($unsigned({1'b0, inc_cur}) + $unsigned(step));
          if (inc_nxt == inc_tgt) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      inc_cur <= '0;
      inc_tgt <= '0;
    end else begin
      state   <= state_nxt;
      inc_cur <= inc_nxt;
      inc_tgt <= tgt_nxt;
    end
  end
`else
  assign freq_ready = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        inc_cur <= '0;
    else if (accept) inc_cur <= freq_in;
  end
`endif

endmodule

// File: tb/tb_saw_gen.sv
// Directed self-checking bench for saw_gen; default build checks ramp/sync/reset,
// GLIDE_EN build checks portamento and reset mid-glide.
module tb_saw_gen;
  localparam int ACC_W = 24, OUT_W = 11;

  logic             clk = 1'b0, rst = 1'b0, tick_en = 1'b0;
  logic [ACC_W-1:0] freq_in = '0;
  logic             freq_valid = 1'b0, sync_in = 1'b0;
  logic             freq_ready, wrap_pulse;
  logic [OUT_W-1:0] saw_out;

  int checks = 0, failures = 0;

  saw_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .GLIDE_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .freq_in(freq_in),
    .freq_valid(freq_valid), .freq_ready(freq_ready), .sync_in(sync_in),
    .saw_out(saw_out), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_saw", saw_out, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_ready", freq_ready, 1);
    step(); step();
    rst = 1'b1;
    step();

`ifndef GLIDE_EN
    // Accept edge with a tick: old increment (0) is used on that edge.
    freq_in = 24'h010000; freq_valid = 1'b1; tick_en = 1'b1;
    step();
    chk("accept_edge_saw", saw_out, 0);
    chk("ready_nog", freq_ready, 1);
    freq_valid = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      step();
      chk("ramp_saw", saw_out, (8 * k) % 2048);
      chk("ramp_wrap", wrap_pulse, (k % 256 == 0) ? 1 : 0);
    end
    // saw = 32; ramp to 800 then hard-sync with a level held 10 cycles
    for (int k = 0; k < 96; k++) step();
    chk("pre_sync_saw", saw_out, 800);
    sync_in = 1'b1;
    step();
    chk("sync_saw", saw_out, 0);
    chk("sync_wrap", wrap_pulse, 0);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("sync_hold_saw", saw_out, 8 * j);
    end
    sync_in = 1'b0;
    step();
    chk("sync_rel_saw", saw_out, 80);
    // Ramp to the last step before overflow, then collide sync with tick.
    for (int k = 0; k < 245; k++) step();
    chk("near_ovf_saw", saw_out, 2040);
    sync_in = 1'b1;
    step();
    chk("collide_saw", saw_out, 0);
    chk("collide_wrap", wrap_pulse, 0);
    sync_in = 1'b0;
    step();
    chk("post_collide_saw", saw_out, 8);
    // Hold tick low: phase freezes.
    tick_en = 1'b0;
    step(); step();
    chk("tick_off_saw", saw_out, 8);
    chk("tick_off_wrap", wrap_pulse, 0);
    // Async reset mid-ramp.
    tick_en = 1'b1;
    step(); step();
    chk("pre_rst_saw", saw_out, 24);
    rst = 1'b0;
    #1;
    chk("mid_rst_saw", saw_out, 0);
    chk("mid_rst_wrap", wrap_pulse, 0);
    chk("mid_rst_ready", freq_ready, 1);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_saw", saw_out, 0);
    freq_in = 24'h010000; freq_valid = 1'b1;
    step();
    chk("reacc_saw", saw_out, 0);
    freq_valid = 1'b0;
    step();
    chk("reacc_tick_saw", saw_out, 8);
    step();
    chk("reacc_tick2_saw", saw_out, 16);
    // Zero frequency: accept edge still uses old 0x010000.
    freq_in = '0; freq_valid = 1'b1;
    step();
    chk("zero_acc_saw", saw_out, 24);
    freq_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      chk("zero_wrap", wrap_pulse, 0);
    end
    chk("zero_saw", saw_out, 24);
`else
    begin
      int ph, inc, tgt, d, s, n;
      ph = 0; inc = 0; tgt = 24'h000400;
      freq_in = 24'h000400; freq_valid = 1'b1; tick_en = 1'b0;
      step();
      chk("glide_ready_lo", freq_ready, 0);
      freq_valid = 1'b0;
      n = 0;
      while (inc != tgt && n < 3000) begin
        tick_en = 1'b1;
        // Offer a different word mid-glide; it must not be taken.
        if (n == 5) begin freq_in = 24'h000100; freq_valid = 1'b1; end
        else freq_valid = 1'b0;
        step();
        ph = (ph + inc) & 32'h00FF_FFFF;
        d = tgt - inc;
        s = d >>> 8;
        if (s == 0) s = (d < 0) ? -1 : 1;
        inc = inc + s;
        chk("glide_saw", saw_out, ph >> 13);
        chk("glide_ready", freq_ready, (inc == tgt) ? 1 : 0);
        n++;
      end
      chk("glide_bounded", (n < 3000) ? 1 : 0, 1);
      freq_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
        step();
        ph = (ph + inc) & 32'h00FF_FFFF;
      end
      chk("post_glide_saw", saw_out, ph >> 13);
      chk("post_glide_ready", freq_ready, 1);
      // Reset mid-glide.
      freq_in = 24'h000800; freq_valid = 1'b1; tick_en = 1'b0;
      step();
      freq_valid = 1'b0;
      chk("glide2_ready", freq_ready, 0);
      tick_en = 1'b1;
      step(); step(); step();
      chk("glide2_busy", freq_ready, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_saw", saw_out, 0);
      chk("mid_rst_wrap", wrap_pulse, 0);
      chk("mid_rst_ready", freq_ready, 1);
      step();
      rst = 1'b1; tick_en = 1'b0;
      step();
      freq_in = 24'h000040; freq_valid = 1'b1;
      step();
      freq_valid = 1'b0;
      chk("reacc_ready", freq_ready, 0);
      tick_en = 1'b1;
      // |d| < 256 throughout: 64 unit steps from 0 to 0x40.
      for (int k = 1; k <= 64; k++) begin
        step();
        if (k == 63) chk("unit_step_busy", freq_ready, 0);
      end
      chk("unit_step_done", freq_ready, 1);
      chk("unit_step_saw", saw_out, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
